// File: rtl/traffic_phase_sequencer.sv
// Timing and sequencing controller for a highway/country-road intersection.
// Handles the dwell intervals, the latched country request and the emergency preempt.
module traffic_phase_sequencer #(
    parameter int MIN_HWY_GREEN   = 8,
    parameter int YELLOW_TIME     = 3,
    parameter int ALL_RED_TIME    = 2,
    parameter int MAX_CNTRY_GREEN = 10,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             emg,
    output logic [1:0]       hwy,
    output logic [1:0]       cntry,
    output logic [2:0]       state,
    output logic             req,
    output logic [CNT_W-1:0] timer
);

    typedef enum logic [2:0] {
        PH_HG  = 3'd0,
        PH_HY  = 3'd1,
        PH_AR1 = 3'd2,
        PH_CG  = 3'd3,
        PH_CY  = 3'd4,
        PH_AR2 = 3'd5
    } phase_e;

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;

    // A phase of dwell N exits on the edge where the timer shows N-1.
    localparam logic [CNT_W-1:0] HG_LAST   = CNT_W'(MIN_HWY_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] CG_LAST   = CNT_W'(MAX_CNTRY_GREEN - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX = '1;

    // Kept as raw bits so the illegal encodings 6 and 7 stay observable and recoverable.
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             req_q, req_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PH_HG;
            timer_q <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PH_HG:   if (timer_q >= HG_LAST && req_q && !emg) state_d = PH_HY;
            PH_HY:   if (timer_q == Y_LAST) state_d = PH_AR1;
            PH_AR1:  if (timer_q == AR_LAST) state_d = emg ? PH_HG : PH_CG;
            PH_CG:   if (!x || emg || timer_q == CG_LAST) state_d = PH_CY;
            PH_CY:   if (timer_q == Y_LAST) state_d = PH_AR2;
            PH_AR2:  if (timer_q == AR_LAST) state_d = PH_HG;
            default: state_d = PH_HG;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        // Entering CG serves the request; that clear beats a same-edge set.
        if (state_q == PH_AR1 && state_d == PH_CG) begin
            req_d = 1'b0;
        end else if (x && state_q != PH_CG) begin
            req_d = 1'b1;
        end else begin
            req_d = req_q;
        end
    end

    always_comb begin
        hwy   = LAMP_GREEN;
        cntry = LAMP_RED;
        case (state_q)
            PH_HY: begin
                hwy   = LAMP_YELLOW;
            end
            PH_AR1, PH_AR2: begin
                hwy   = LAMP_RED;
            end
            PH_CG: begin
                hwy   = LAMP_RED;
                cntry = LAMP_GREEN;
            end
            PH_CY: begin
                hwy   = LAMP_RED;
                cntry = LAMP_YELLOW;
            end
            default: begin
                hwy   = LAMP_GREEN;
                cntry = LAMP_RED;
            end
        endcase
    end

    assign state = state_q;
    assign timer = timer_q;
    assign req   = req_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer: stimulus queues expected post-edge
// phase/timer/request values, a monitor compares them after every rising edge.
module tb_traffic_phase_sequencer;

    localparam logic [2:0] S_HG  = 3'd0;
    localparam logic [2:0] S_HY  = 3'd1;
    localparam logic [2:0] S_AR1 = 3'd2;
    localparam logic [2:0] S_CG  = 3'd3;
    localparam logic [2:0] S_CY  = 3'd4;
    localparam logic [2:0] S_AR2 = 3'd5;

    typedef struct {
        logic [2:0] st;
        logic [7:0] tmr;
        logic       rq;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x   = 1'b0;
    logic       emg = 1'b0;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] state;
    logic       req;
    logic [7:0] timer;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    traffic_phase_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .emg   (emg),
        .hwy   (hwy),
        .cntry (cntry),
        .state (state),
        .req   (req),
        .timer (timer)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] hwy_of(input logic [2:0] st);
        case (st)
            S_HG:    return 2'd2;
            S_HY:    return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] cntry_of(input logic [2:0] st);
        case (st)
            S_CG:    return 2'd2;
            S_CY:    return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // Called at a falling edge: drive inputs for the next rising edge and queue its outcome.
    task automatic step(input logic xi, input logic ei, input logic [2:0] st,
                        input int tmr, input logic rq);
        exp_t e;
        x   = xi;
        emg = ei;
        e.st  = st;
        e.tmr = 8'(tmr);
        e.rq  = rq;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic phase(input logic xi, input logic ei, input logic [2:0] st,
                         input int t0, input int t1, input logic rq);
        for (int t = t0; t <= t1; t++) step(xi, ei, st, t, rq);
    endtask

    // Asserts reset between edges, checks it takes effect without a clock, releases at a falling edge.
    task automatic do_reset(input string tag);
        x   = 1'b0;
        emg = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check({tag, "_rst_state"}, 32'(state), 32'(S_HG));
        check({tag, "_rst_hwy"},   32'(hwy),   32'd2);
        check({tag, "_rst_cntry"}, 32'(cntry), 32'd0);
        check({tag, "_rst_timer"}, 32'(timer), 32'd0);
        check({tag, "_rst_req"},   32'(req),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("safety", 32'(hwy != 2'd0 && cntry != 2'd0), 32'd0);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("state", 32'(state), 32'(e.st));
                    check("timer", 32'(timer), 32'(e.tmr));
                    check("req",   32'(req),   32'(e.rq));
                    check("hwy",   32'(hwy),   32'(hwy_of(e.st)));
                    check("cntry", 32'(cntry), 32'(cntry_of(e.st)));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        @(negedge clk);
        do_reset("init");

        // Idle: HG holds forever, timer counts and saturates at 255.
        for (int k = 1; k <= 300; k++) step(1'b0, 1'b0, S_HG, (k > 255) ? 255 : k, 1'b0);

        // Held request after 20 idle cycles: full cycle with max-green timeout.
        do_reset("held");
        phase(1'b0, 1'b0, S_HG, 1, 20, 1'b0);
        step(1'b1, 1'b0, S_HG, 21, 1'b1);
        phase(1'b1, 1'b0, S_HY, 0, 2, 1'b1);
        phase(1'b1, 1'b0, S_AR1, 0, 1, 1'b1);
        phase(1'b1, 1'b0, S_CG, 0, 9, 1'b0);
        step(1'b1, 1'b0, S_CY, 0, 1'b0);
        phase(1'b1, 1'b0, S_CY, 1, 2, 1'b1);
        phase(1'b1, 1'b0, S_AR2, 0, 1, 1'b1);
        phase(1'b1, 1'b0, S_HG, 0, 7, 1'b1);
        step(1'b0, 1'b0, S_HY, 0, 1'b1);

        // One-cycle pulse at HG timer 2: minimum green, then CG lasts one cycle with x low.
        do_reset("pulse");
        phase(1'b0, 1'b0, S_HG, 1, 2, 1'b0);
        step(1'b1, 1'b0, S_HG, 3, 1'b1);
        phase(1'b0, 1'b0, S_HG, 4, 7, 1'b1);
        phase(1'b0, 1'b0, S_HY, 0, 2, 1'b1);
        phase(1'b0, 1'b0, S_AR1, 0, 1, 1'b1);
        step(1'b0, 1'b0, S_CG, 0, 1'b0);
        phase(1'b0, 1'b0, S_CY, 0, 2, 1'b0);
        phase(1'b0, 1'b0, S_AR2, 0, 1, 1'b0);
        phase(1'b0, 1'b0, S_HG, 0, 12, 1'b0);

        // Emergency in CG at timer 4, held through the return to HG with a pending request.
        do_reset("emg_cg");
        phase(1'b1, 1'b0, S_HG, 1, 7, 1'b1);
        phase(1'b1, 1'b0, S_HY, 0, 2, 1'b1);
        phase(1'b1, 1'b0, S_AR1, 0, 1, 1'b1);
        phase(1'b1, 1'b0, S_CG, 0, 4, 1'b0);
        step(1'b1, 1'b1, S_CY, 0, 1'b0);
        phase(1'b1, 1'b1, S_CY, 1, 2, 1'b1);
        phase(1'b1, 1'b1, S_AR2, 0, 1, 1'b1);
        phase(1'b1, 1'b1, S_HG, 0, 10, 1'b1);
        step(1'b1, 1'b0, S_HY, 0, 1'b1);

        // Emergency during HY: yellow and all-red complete, then straight back to HG.
        do_reset("emg_hy");
        step(1'b1, 1'b0, S_HG, 1, 1'b1);
        phase(1'b0, 1'b0, S_HG, 2, 7, 1'b1);
        step(1'b0, 1'b0, S_HY, 0, 1'b1);
        phase(1'b0, 1'b1, S_HY, 1, 2, 1'b1);
        phase(1'b0, 1'b1, S_AR1, 0, 1, 1'b1);
        phase(1'b0, 1'b1, S_HG, 0, 3, 1'b1);
        phase(1'b0, 1'b0, S_HG, 4, 7, 1'b1);
        step(1'b0, 1'b0, S_HY, 0, 1'b1);

        // Drive into CY, then reset between edges (do_reset checks the immediate effect).
        do_reset("pre_cy");
        step(1'b1, 1'b0, S_HG, 1, 1'b1);
        phase(1'b0, 1'b0, S_HG, 2, 7, 1'b1);
        phase(1'b0, 1'b0, S_HY, 0, 2, 1'b1);
        phase(1'b0, 1'b0, S_AR1, 0, 1, 1'b1);
        step(1'b0, 1'b0, S_CG, 0, 1'b0);
        phase(1'b0, 1'b0, S_CY, 0, 1, 1'b0);
        do_reset("mid_cy");
        phase(1'b0, 1'b0, S_HG, 1, 3, 1'b0);

        @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Timed sequencer for a highway/country-road intersection. It drives the 2-bit highway and country signal heads.
- It enforces a minimum highway green, fixed yellow and all-red clearance intervals, and a maximum country green. A country-road car request is latched so it is never lost.
- An emergency preempt input forces the intersection back to highway green.
- It sits above the existing highway/country signal FSM as its timing and sequencing controller. It is driven by the country-road sensor x.

Parameters:
- MIN_HWY_GREEN, 8: minimum highway-green dwell in clock cycles, >=1.
- YELLOW_TIME, 3: yellow dwell in cycles for either road, >=1.
- ALL_RED_TIME, 2: all-red clearance dwell in cycles, >=1.
- MAX_CNTRY_GREEN, 10: maximum country-green dwell in cycles, >=1.
- CNT_W, 8: dwell timer width. All time parameters must be <= 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- x  input  1  country-road car sensor, 1 = car waiting.
- emg  input  1  emergency preempt, 1 = return to and hold highway green.
- hwy  output  2  highway signal head: RED=2'd0, YELLOW=2'd1, GREEN=2'd2.
- cntry  output  2  country signal head, same encoding.
- state  output  3  current phase: HG=0, HY=1, AR1=2, CG=3, CY=4, AR2=5.
- req  output  1  latched country request.
- timer  output  CNT_W  cycles spent in the current phase.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=HG, hwy=GREEN, cntry=RED, timer=0, req=0.
  - Applies immediately, from any phase, mid-interval included.
- Moore outputs, decoded from the state register only:
  - HG: hwy=GREEN, cntry=RED.
  - HY: hwy=YELLOW, cntry=RED.
  - AR1: both RED.
  - CG: hwy=RED, cntry=GREEN.
  - CY: hwy=RED, cntry=YELLOW.
  - AR2: both RED.
  - Values 6 and 7 are illegal and go to HG on the next edge with outputs HG-style.
- Timer:
  - Clears to 0 on the edge that changes state; otherwise increments each cycle.
  - Saturates at 2^CNT_W-1 (no wrap).
  - A phase with dwell N lasts exactly N cycles: it exits on the edge where timer==N-1.
- Request latch:
  - Sets on any edge where x=1 and state != CG.
  - Clears on the AR1->CG edge; clear wins over set on that edge.
  - x during CG does not set req, since that car is being served.
  - x during CY/AR2 sets req, and the request is served next cycle round.
- Transitions, evaluated on each rising edge using the current req, x and emg values:
  - HG->HY: timer >= MIN_HWY_GREEN-1, req=1 and emg=0. Otherwise hold HG indefinitely.
  - HY->AR1: timer == YELLOW_TIME-1, regardless of emg.
  - AR1->CG: timer == ALL_RED_TIME-1 and emg=0.
  - AR1->HG: timer == ALL_RED_TIME-1 and emg=1. The country phase is skipped and req stays 1.
  - CG->CY: x=0, or emg=1, or timer == MAX_CNTRY_GREEN-1. CG therefore lasts at least 1 cycle.
  - CY->AR2: timer == YELLOW_TIME-1.
  - AR2->HG: timer == ALL_RED_TIME-1.
- Safety invariant: hwy and cntry are never both non-RED in the same cycle. Every green-to-green handover passes through YELLOW then all-red.
- Simultaneous events:
  - emg=1 together with req=1 in HG: HG holds.
  - emg arriving in HY completes the yellow and all-red intervals, then returns to HG.
  - x and emg both 1 in CG: exit to CY.

Test Plan:
- Reset, x=0, emg=0 for 30 cycles -> state=HG, hwy=2, cntry=0, req=0 throughout; timer reaches 30 and keeps counting (saturates only at 255).
- After 20 idle cycles, hold x=1 -> req=1 next edge, HY on the edge after. Then:
  - HY for 3 cycles, AR1 for 2 cycles, CG for exactly 10 cycles (max-green timeout).
  - CY for 3 cycles; req re-sets during CY because x=1.
  - AR2 for 2 cycles, then HG for exactly 8 cycles, then HY again.
- 1-cycle x pulse at HG timer=2 -> req latched; HY entered on the edge where timer=7 (HG dwell exactly 8 cycles). In CG, x=0 gives CY after 1 CG cycle.
- In CG at timer=4, raise emg -> CY on the next edge. Keep emg=1 with x=1 -> AR2, then HG, which holds while emg=1 even though req=1. Drop emg -> HY on the next edge.
- emg rises during HY -> HY and AR1 complete (3 and 2 cycles), then AR1->HG directly; CG is never entered and req remains 1.
- Assert rst=0 mid-CY between clock edges -> hwy=2, cntry=0, state=0, timer=0, req=0 immediately, without waiting for an edge. Check that hwy and cntry are never both non-RED across all scenarios.
